// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection lamp-bus monitor.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED,
        YEL,
        GRN,
        BAD
    } lamp_e;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_ARMED,
        ST_FAULT
    } mon_state_e;

    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_ENC         = 3'd1;
    localparam logic [2:0] FC_CONFLICT    = 3'd2;
    localparam logic [2:0] FC_SEQ         = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN = 3'd4;
    localparam logic [2:0] FC_LONG_GREEN  = 3'd5;
    localparam logic [2:0] FC_YELLOW      = 3'd6;

    function automatic lamp_e encode_lamp(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return GRN;
            3'b010:  return YEL;
            3'b001:  return RED;
            default: return BAD;
        endcase
    endfunction

endpackage

// File: rtl/lamp_checker.sv
// Per-approach lamp sampler, previous-lamp tracker, dwell counter and rule flags.
module lamp_checker
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 20,
    parameter int YELLOW_TIME = 3,
    parameter int CNT_W       = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick,
    input  logic  g_i,
    input  logic  y_i,
    input  logic  r_i,
    input  logic  in_sync_i,
    output lamp_e lamp_o,
    output logic  enc_o,
    output logic  seq_o,
    output logic  short_o,
    output logic  long_o,
    output logic  yel_o
);

    logic [2:0]       samp_q;
    lamp_e            prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fresh_q, fresh_d;
    lamp_e            cur;
    logic             change;
    logic             legal;

    // Sample resets to all-dark so a reset value is never mistaken for a both-red sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q  <= '0;
            prev_q  <= RED;
            cnt_q   <= '0;
            fresh_q <= 1'b1;
        end else begin
            samp_q  <= {g_i, y_i, r_i};
            prev_q  <= cur;
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
        end
    end

    always_comb begin
        cur    = encode_lamp(samp_q[2], samp_q[1], samp_q[0]);
        change = (cur != prev_q);
        legal  = ((prev_q == GRN) && (cur == YEL)) ||
                 ((prev_q == YEL) && (cur == RED)) ||
                 ((prev_q == RED) && (cur == GRN));

        cnt_d = cnt_q;
        if (change)
            cnt_d = '0;
        else if (tick && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);

        // First transition after arming is exempt from sequence and dwell checks.
        fresh_d = fresh_q;
        if (in_sync_i)
            fresh_d = 1'b1;
        else if (change)
            fresh_d = 1'b0;

        lamp_o  = cur;
        enc_o   = (cur == BAD);
        seq_o   = !fresh_q && change && !legal;
        short_o = !fresh_q && (prev_q == GRN) && (cur == YEL) && (cnt_q < CNT_W'(MIN_GREEN));
        yel_o   = !fresh_q && (prev_q == YEL) && (cur == RED) && (cnt_q != CNT_W'(YELLOW_TIME));
        long_o  = !change && (cur == GRN) && (cnt_q >= CNT_W'(MAX_GREEN + 1));
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-bus monitor: latches the first rule violation and requests flashing fail-safe.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 20,
    parameter int YELLOW_TIME = 3,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       g1,
    input  logic       y1,
    input  logic       r1,
    input  logic       g2,
    input  logic       y2,
    input  logic       r2,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       force_flash,
    output logic       armed
);

    mon_state_e state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [2:0] viol;
    lamp_e      lamp1, lamp2;
    logic       enc1, seq1, short1, long1, yel1;
    logic       enc2, seq2, short2, long2, yel2;
    logic       in_sync, both_r, conflict;

    assign in_sync = (state_q == ST_SYNC);

    lamp_checker #(
        .MIN_GREEN  (MIN_GREEN),
        .MAX_GREEN  (MAX_GREEN),
        .YELLOW_TIME(YELLOW_TIME),
        .CNT_W      (CNT_W)
    ) u_chk1 (
        .clk(clk), .reset(reset), .tick(tick),
        .g_i(g1), .y_i(y1), .r_i(r1), .in_sync_i(in_sync),
        .lamp_o(lamp1), .enc_o(enc1), .seq_o(seq1),
        .short_o(short1), .long_o(long1), .yel_o(yel1)
    );

    lamp_checker #(
        .MIN_GREEN  (MIN_GREEN),
        .MAX_GREEN  (MAX_GREEN),
        .YELLOW_TIME(YELLOW_TIME),
        .CNT_W      (CNT_W)
    ) u_chk2 (
        .clk(clk), .reset(reset), .tick(tick),
        .g_i(g2), .y_i(y2), .r_i(r2), .in_sync_i(in_sync),
        .lamp_o(lamp2), .enc_o(enc2), .seq_o(seq2),
        .short_o(short2), .long_o(long2), .yel_o(yel2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        both_r   = (lamp1 == RED) && (lamp2 == RED);
        conflict = (lamp1 != RED) && (lamp2 != RED);

        if (enc1 || enc2)          viol = FC_ENC;
        else if (conflict)         viol = FC_CONFLICT;
        else if (seq1 || seq2)     viol = FC_SEQ;
        else if (short1 || short2) viol = FC_SHORT_GREEN;
        else if (long1 || long2)   viol = FC_LONG_GREEN;
        else if (yel1 || yel2)     viol = FC_YELLOW;
        else                       viol = FC_NONE;

        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_SYNC: begin
                if (both_r)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (viol != FC_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = viol;
                end
            end
            ST_FAULT: begin
                if (clear && both_r) begin
                    state_d = ST_SYNC;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = ST_SYNC;
                code_d  = FC_NONE;
            end
        endcase
    end

    assign fault       = (state_q == ST_FAULT);
    assign force_flash = fault;
    assign armed       = (state_q == ST_ARMED);
    assign fault_code  = code_q;

endmodule
